dk_sound_mixer: RTL
===================

DK_SOUND_MIXER -- requirements
Module: dk_sound_mixer

Interface
REQ-001 SHALL have parameter GAIN0, default 16384, walk channel gain, unsigned Q2.14 (16384 = 1.0).
REQ-002 SHALL have parameter GAIN1, default 16384, jump channel gain, unsigned Q2.14.
REQ-003 SHALL have parameter GAIN2, default 16384, stomp channel gain, unsigned Q2.14.
REQ-004 SHALL have parameter DC_SHIFT, default 8, DC-blocker pole shift (used only with DC_BLOCK_EN).
REQ-005 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-006 SHALL have port I_RST  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port audio_clk_en  input  1  one-cycle sample strobe.
REQ-008 SHALL have port walk_in  input  16  signed walk channel sample, as produced by the walk sound stage.
REQ-009 SHALL have port jump_in  input  16  signed jump channel sample.
REQ-010 SHALL have port stomp_in  input  16  signed stomp channel sample.
REQ-011 SHALL have port out  output  16  signed mixed sample, registered.
REQ-012 SHALL have port out_valid  output  1  one-cycle pulse when out updates.
REQ-013 SHALL have port overrun  output  1  sticky flag: strobe arrived while busy.

Function
REQ-014 SHALL implement FSM states IDLE, MAC0, MAC1, MAC2, [DCB], SAT; DCB exists only with DC_BLOCK_EN.
REQ-015 SHALL, in IDLE on audio_clk_en=1, snapshot all three inputs, clear the accumulator and go to MAC0; IDLE otherwise holds.
REQ-016 SHALL, in MACk, add (snapshot_k * GAINk) >>> 14 (signed x unsigned, 33-bit product, arithmetic shift) into a 20-bit signed accumulator; one channel per cycle, one shared multiplier.
REQ-017 SHALL advance MAC0->MAC1->MAC2->SAT (or MAC2->DCB->SAT) unconditionally, one state per clock.
REQ-018 SHALL, in SAT, clamp the value to [-32768, 32767], register it to out, pulse out_valid for exactly one cycle, and return to IDLE.
REQ-019 SHALL give latency: out/out_valid visible 4 clock edges after the capturing edge (5 with DC_BLOCK_EN).
REQ-020 SHALL, on audio_clk_en=1 in any state other than IDLE, ignore the strobe, leave the in-flight computation unaffected and set overrun=1.
REQ-021 SHALL accept a strobe in the cycle where out_valid=1 (state is IDLE then).
REQ-022 SHALL hold out between updates; overrun clears only on reset.
REQ-023 SHALL not change out when all gains are 0 other than to write 0.

Reset
REQ-024 SHALL, while I_RST=1 at a clock edge, force state IDLE, out=0, out_valid=0, overrun=0, accumulator=0, DC-blocker history=0, regardless of state; an interrupted computation produces no output.
REQ-025 SHALL ignore audio_clk_en on the edge where I_RST=1.

Configuration
REQ-026 SHALL compile the DC blocker in when macro DK_SOUND_MIXER_DC_BLOCK_EN is defined: in DCB, y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT), 20-bit signed, x = accumulator, then x_prev=x, y_prev=y, SAT clamps y.
REQ-027 SHALL, without DK_SOUND_MIXER_DC_BLOCK_EN, omit DCB state and history registers; SAT clamps the accumulator directly.

Verification
REQ-028 SHALL cover: gains 16384, inputs 1000/2000/3000, one strobe -> out=6000, out_valid single pulse 4 edges after capture (no DC block).
REQ-029 SHALL cover: inputs 30000/30000/0 -> out=32767; inputs -30000/-30000/0 -> out=-32768.
REQ-030 SHALL cover: GAIN0=8192, GAIN1=32768, walk_in=-1000, jump_in=500, stomp_in=0 -> out=500.
REQ-031 SHALL cover: second strobe 2 cycles after the first -> overrun=1 and stays 1, first result unchanged, no extra out_valid; strobe coincident with out_valid -> accepted, no overrun.
REQ-032 SHALL cover: I_RST asserted during MAC1 -> next cycle out=0, out_valid=0, overrun=0, no out_valid afterwards until a new strobe.
REQ-033 SHALL cover (DC_BLOCK_EN, DC_SHIFT=8): constant 8000 on walk_in only, repeated strobes -> first out=8000, second 7969, monotonically decaying toward 0.

Source files
------------

// File: rtl/dk_sound_mixer.sv
// dk_sound_mixer: three-channel gain/mix with saturation, one shared multiplier.
// Define DK_SOUND_MIXER_DC_BLOCK_EN to insert a one-pole DC blocker before saturation.
module dk_sound_mixer #(
    parameter int unsigned GAIN0    = 16384,
    parameter int unsigned GAIN1    = 16384,
    parameter int unsigned GAIN2    = 16384,
    parameter int unsigned DC_SHIFT = 8
) (
    input  logic        clk,
    input  logic        I_RST,
    input  logic        audio_clk_en,
    input  logic [15:0] walk_in,
    input  logic [15:0] jump_in,
    input  logic [15:0] stomp_in,
    output logic [15:0] out,
    output logic        out_valid,
    output logic        overrun
);
    typedef enum logic [2:0] {
        IDLE, MAC0, MAC1, MAC2,
`ifdef DK_SOUND_MIXER_DC_BLOCK_EN
        DCB,
`endif
        SAT
    } state_t;

    localparam logic signed [16:0] G0 = 17'(GAIN0);
    localparam logic signed [16:0] G1 = 17'(GAIN1);
    localparam logic signed [16:0] G2 = 17'(GAIN2);

    state_t             r_state, w_next;
    logic signed [15:0] r_walk, r_jump, r_stomp;
    logic signed [19:0] r_acc;
    logic signed [15:0] w_mul_a;
    logic signed [16:0] w_mul_g;
    logic signed [32:0] w_prod;
    logic signed [19:0] w_term;
    logic signed [19:0] w_sat_in;
    logic        [15:0] w_sat;

    always_ff @(posedge clk) r_state <= I_RST ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = audio_clk_en ? MAC0 : IDLE;
            MAC0:    w_next = MAC1;
            MAC1:    w_next = MAC2;
`ifdef DK_SOUND_MIXER_DC_BLOCK_EN
            MAC2:    w_next = DCB;
            DCB:     w_next = SAT;
`else
            MAC2:    w_next = SAT;
`endif
            SAT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Gains are unsigned Q2.14; a zero MSB makes them safe as signed multiplier operands.
    assign w_mul_a = r_state == MAC0 ? r_walk : r_state == MAC1 ? r_jump : r_stomp;
    assign w_mul_g = r_state == MAC0 ? G0 : r_state == MAC1 ? G1 : G2;
    assign w_prod  = 33'(w_mul_a) * 33'(w_mul_g);
    assign w_term  = 20'(w_prod >>> 14);

`ifdef DK_SOUND_MIXER_DC_BLOCK_EN
    logic signed [19:0] r_xp, r_yp, w_y;
    assign w_y      = r_acc - r_xp + r_yp - (r_yp >>> DC_SHIFT);
    assign w_sat_in = r_yp;
`else
    logic w_unused_dc;
    assign w_unused_dc = |DC_SHIFT;
    assign w_sat_in    = r_acc;
`endif

    assign w_sat = w_sat_in > 20'sd32767  ? 16'h7fff :
                   w_sat_in < -20'sd32768 ? 16'h8000 : w_sat_in[15:0];

    always_ff @(posedge clk) begin
        if (I_RST) begin
            r_walk    <= '0;
            r_jump    <= '0;
            r_stomp   <= '0;
            r_acc     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef DK_SOUND_MIXER_DC_BLOCK_EN
            r_xp      <= '0;
            r_yp      <= '0;
`endif
        end else begin
            if (r_state == IDLE && audio_clk_en) begin
                r_walk  <= walk_in;
                r_jump  <= jump_in;
                r_stomp <= stomp_in;
                r_acc   <= '0;
            end
            if (r_state == MAC0 || r_state == MAC1 || r_state == MAC2)
                r_acc <= r_acc + w_term;
`ifdef DK_SOUND_MIXER_DC_BLOCK_EN
            if (r_state == DCB) begin
                r_xp <= r_acc;
                r_yp <= w_y;
            end
`endif
            if (r_state == SAT)
                out <= w_sat;
            out_valid <= r_state == SAT;
            if (audio_clk_en && r_state != IDLE)
                overrun <= 1'b1;
        end
    end
endmodule
